dma_frontend_axil_regs: RTL and testbench



---
 rtl/dma_frontend_axil_regs.sv | 132 +++++++++++++
 tb/tb_dma_frontend_axil_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_frontend_axil_regs.sv
// AXI4-Lite control register file for the DMA frontend: descriptor registers,
// status/done readback and a launch pulse on NEXT_ID reads.
module dma_frontend_axil_regs #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned BlockAw   = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [AddrWidth-1:0]   aw_addr_i,
   input  logic                   aw_valid_i,
   output logic                   aw_ready_o,
   input  logic [DataWidth-1:0]   w_data_i,
   input  logic [DataWidth/8-1:0] w_strb_i,
   input  logic                   w_valid_i,
   output logic                   w_ready_o,
   output logic [1:0]             b_resp_o,
   output logic                   b_valid_o,
   input  logic                   b_ready_i,
   input  logic [AddrWidth-1:0]   ar_addr_i,
   input  logic                   ar_valid_i,
   output logic                   ar_ready_o,
   output logic [DataWidth-1:0]   r_data_o,
   output logic [1:0]             r_resp_o,
   output logic                   r_valid_o,
   input  logic                   r_ready_i,
   input  logic                   backend_idle_i,
   input  logic                   done_i,
   output logic [31:0]            src_addr_o,
   output logic [31:0]            dst_addr_o,
   output logic [31:0]            num_bytes_o,
   output logic                   launch_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned IdxWidth  = BlockAw - 2;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   localparam logic [IdxWidth-1:0] IdxSrc    = IdxWidth'(0);
   localparam logic [IdxWidth-1:0] IdxDst    = IdxWidth'(1);
   localparam logic [IdxWidth-1:0] IdxNbytes = IdxWidth'(2);
   localparam logic [IdxWidth-1:0] IdxStatus = IdxWidth'(3);
   localparam logic [IdxWidth-1:0] IdxNextId = IdxWidth'(4);
   localparam logic [IdxWidth-1:0] IdxDone   = IdxWidth'(5);

   logic [DataWidth-1:0] src_q, dst_q, nbytes_q;
   logic [IdxWidth-1:0]  wr_idx_c, rd_idx_c;
   logic                 wr_en_c, rd_en_c, wr_err_c, rd_err_c;
   logic [DataWidth-1:0] rd_data_c;
   logic                 unused_addr;

   assign wr_idx_c = aw_addr_i[BlockAw-1:2];
   assign rd_idx_c = ar_addr_i[BlockAw-1:2];
   assign unused_addr = ^{aw_addr_i, ar_addr_i};

   // Write wins arbitration; a read waits one cycle behind it.
   assign wr_en_c = aw_valid_i & w_valid_i & ~b_valid_o & ~rst_i;
   assign rd_en_c = ar_valid_i & ~r_valid_o & ~rst_i & ~wr_en_c;

   assign aw_ready_o = wr_en_c;
   assign w_ready_o  = wr_en_c;
   assign ar_ready_o = rd_en_c;
   assign wr_err_c   = wr_idx_c > IdxDone;
   assign launch_o   = rd_en_c & (rd_idx_c == IdxNextId);

   assign src_addr_o  = src_q;
   assign dst_addr_o  = dst_q;
   assign num_bytes_o = nbytes_q;

   // Read mux; unmapped offsets return zero with SLVERR.
   always_comb begin
      rd_data_c = '0;
      rd_err_c  = 1'b0;
      case (rd_idx_c)
         IdxSrc:    rd_data_c = src_q;
         IdxDst:    rd_data_c = dst_q;
         IdxNbytes: rd_data_c = nbytes_q;
         IdxStatus: rd_data_c = {{(DataWidth-1){1'b0}}, backend_idle_i};
         IdxNextId: rd_data_c = '0;
         IdxDone:   rd_data_c = {{(DataWidth-1){1'b0}}, done_i};
         default:   rd_err_c  = 1'b1;
      endcase
   end

   // Descriptor registers with per-byte strobes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q    <= '0;
         dst_q    <= '0;
         nbytes_q <= '0;
      end else if (wr_en_c && !wr_err_c) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (w_strb_i[b]) begin
               case (wr_idx_c)
                  IdxSrc:    src_q[8*b +: 8]    <= w_data_i[8*b +: 8];
                  IdxDst:    dst_q[8*b +: 8]    <= w_data_i[8*b +: 8];
                  IdxNbytes: nbytes_q[8*b +: 8] <= w_data_i[8*b +: 8];
                  default: ;
               endcase
            end
         end
      end
   end

   // Response channels: one outstanding beat each, held until handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b_valid_o <= 1'b0;
         b_resp_o  <= RespOkay;
         r_valid_o <= 1'b0;
         r_data_o  <= '0;
         r_resp_o  <= RespOkay;
      end else begin
         if (wr_en_c) begin
            b_valid_o <= 1'b1;
            b_resp_o  <= wr_err_c ? RespSlverr : RespOkay;
         end else if (b_ready_i) begin
            b_valid_o <= 1'b0;
         end
         if (rd_en_c) begin
            r_valid_o <= 1'b1;
            r_data_o  <= rd_data_c;
            r_resp_o  <= rd_err_c ? RespSlverr : RespOkay;
         end else if (r_ready_i) begin
            r_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dma_frontend_axil_regs.sv
// Scoreboard bench for dma_frontend_axil_regs: expected B/R beats are queued
// at issue time and checked by a response monitor.
module tb_dma_frontend_axil_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] aw_addr = '0;
   logic        aw_valid = 1'b0;
   logic        aw_ready;
   logic [31:0] w_data = '0;
   logic [3:0]  w_strb = '0;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready = 1'b1;
   logic [31:0] ar_addr = '0;
   logic        ar_valid = 1'b0;
   logic        ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_valid;
   logic        r_ready = 1'b1;
   logic        backend_idle = 1'b0;
   logic        done = 1'b0;
   logic [31:0] src_addr, dst_addr, num_bytes;
   logic        launch;

   int n_checks = 0;
   int n_fail   = 0;
   int launch_cnt = 0;

   logic [1:0]  bq[$];
   logic [33:0] rq[$];

   always #5 clk = ~clk;

   dma_frontend_axil_regs dut (
      .clk_i(clk), .rst_i(rst),
      .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
      .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
      .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
      .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
      .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
      .backend_idle_i(backend_idle), .done_i(done),
      .src_addr_o(src_addr), .dst_addr_o(dst_addr), .num_bytes_o(num_bytes),
      .launch_o(launch)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Response monitor: a beat handshakes at the next rising edge.
   always @(negedge clk) begin
      if (launch) launch_cnt++;
      if (!rst && b_valid && b_ready) begin
         if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
         else check("b_resp", 32'(b_resp), 32'(bq.pop_front()));
      end
      if (!rst && r_valid && r_ready) begin
         if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
         else begin
            logic [33:0] e;
            e = rq.pop_front();
            check("r_data", r_data, e[31:0]);
            check("r_resp", 32'(r_resp), 32'(e[33:32]));
         end
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
      bit got = 0;
      bq.push_back(resp);
      @(posedge clk); #1;
      aw_addr = addr; w_data = data; w_strb = strb;
      aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (aw_ready && w_ready) begin got = 1; break; end
         @(posedge clk); #1;
      end
      if (!got) begin
         check("aw_timeout", 32'd0, 32'd1);
         void'(bq.pop_back());
      end
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      if (got) check("b_latency", 32'(b_valid), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input logic exp_launch);
      bit got = 0;
      rq.push_back({resp, data});
      @(posedge clk); #1;
      ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ar_ready) begin got = 1; break; end
         @(posedge clk); #1;
      end
      if (!got) begin
         check("ar_timeout", 32'd0, 32'd1);
         void'(rq.pop_back());
      end else begin
         check("launch", 32'(launch), 32'(exp_launch));
      end
      @(posedge clk); #1;
      ar_valid = 1'b0;
      @(negedge clk);
      if (got) check("r_latency", 32'(r_valid), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_b_valid", 32'(b_valid), 32'd0);
      check("rst_r_valid", 32'(r_valid), 32'd0);
      check("rst_launch", 32'(launch), 32'd0);
      check("rst_src", src_addr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_read(32'h00, 32'h0, 2'b00, 1'b0);
      do_read(32'h04, 32'h0, 2'b00, 1'b0);
      do_read(32'h08, 32'h0, 2'b00, 1'b0);

      // Descriptor writes with strobes
      do_write(32'h00, 32'h8000_1000, 4'hF, 2'b00);
      check("src_out", src_addr, 32'h8000_1000);
      do_write(32'h08, 32'hFFFF_FFFF, 4'hF, 2'b00);
      do_write(32'h08, 32'h0000_0400, 4'b0011, 2'b00);
      check("nbytes_out", num_bytes, 32'hFFFF_0400);
      do_write(32'h04, 32'h1111_2222, 4'b1010, 2'b00);
      check("dst_strb", dst_addr, 32'h1100_2200);
      do_read(32'h08, 32'hFFFF_0400, 2'b00, 1'b0);
      do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00);

      // NEXT_ID launch pulses
      launch_cnt = 0;
      do_read(32'h10, 32'h0, 2'b00, 1'b1);
      do_read(32'h10, 32'h0, 2'b00, 1'b1);
      check("launch_count", 32'(launch_cnt), 32'd2);

      // STATUS / DONE readback
      backend_idle = 1'b1; done = 1'b0;
      do_read(32'h0C, 32'h1, 2'b00, 1'b0);
      do_read(32'h14, 32'h0, 2'b00, 1'b0);
      backend_idle = 1'b0; done = 1'b1;
      do_read(32'h0C, 32'h0, 2'b00, 1'b0);
      do_read(32'h14, 32'h1, 2'b00, 1'b0);

      // Simultaneous write and read to DST_ADDR with stalled responses
      @(posedge clk); #1;
      b_ready = 1'b0; r_ready = 1'b0;
      aw_addr = 32'h04; w_data = 32'hA5A5_5A5A; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = 32'h04; ar_valid = 1'b1;
      bq.push_back(2'b00);
      rq.push_back({2'b00, 32'hA5A5_5A5A});
      @(negedge clk);
      check("arb_aw_ready", 32'(aw_ready), 32'd1);
      check("arb_ar_ready", 32'(ar_ready), 32'd0);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      check("arb_ar_next", 32'(ar_ready), 32'd1);
      check("arb_b_valid", 32'(b_valid), 32'd1);
      @(posedge clk); #1;
      aw_addr = 32'h00; w_data = 32'hDEAD_BEEF; aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = 32'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_b_valid", 32'(b_valid), 32'd1);
         check("hold_r_valid", 32'(r_valid), 32'd1);
         check("hold_r_data", r_data, 32'hA5A5_5A5A);
         check("hold_aw_ready", 32'(aw_ready), 32'd0);
         check("hold_ar_ready", 32'(ar_ready), 32'd0);
         @(posedge clk); #1;
      end
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      b_ready = 1'b1; r_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("drain_b_valid", 32'(b_valid), 32'd0);
      check("drain_r_valid", 32'(r_valid), 32'd0);
      check("arb_dst", dst_addr, 32'hA5A5_5A5A);
      check("arb_src_kept", src_addr, 32'h8000_1000);

      // Decode boundaries and error responses
      do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10);
      do_read(32'h1C, 32'h0, 2'b10, 1'b0);
      do_read(32'h18, 32'h0, 2'b10, 1'b0);
      do_read(32'h14, 32'h1, 2'b00, 1'b0);
      do_read(32'h0000_0002, 32'h8000_1000, 2'b00, 1'b0);
      do_read(32'h2000_0004, 32'hA5A5_5A5A, 2'b00, 1'b0);
      check("err_src", src_addr, 32'h8000_1000);
      check("err_dst", dst_addr, 32'hA5A5_5A5A);
      check("err_nbytes", num_bytes, 32'hFFFF_0400);

      // Reset while both responses are pending
      @(posedge clk); #1;
      b_ready = 1'b0; r_ready = 1'b0;
      aw_addr = 32'h00; w_data = 32'h1234_5678; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = 32'h08; ar_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(posedge clk); #1;
      ar_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_b_valid", 32'(b_valid), 32'd1);
      check("pre_rst_r_valid", 32'(r_valid), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_aw_ready", 32'(aw_ready), 32'd0);
      check("rst_ar_ready", 32'(ar_ready), 32'd0);
      check("mid_rst_b_valid", 32'(b_valid), 32'd0);
      check("mid_rst_r_valid", 32'(r_valid), 32'd0);
      check("mid_rst_r_data", r_data, 32'd0);
      check("mid_rst_launch", 32'(launch), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      b_ready = 1'b1; r_ready = 1'b1;
      do_read(32'h00, 32'h0, 2'b00, 1'b0);
      do_read(32'h04, 32'h0, 2'b00, 1'b0);
      do_read(32'h08, 32'h0, 2'b00, 1'b0);

      repeat (2) @(posedge clk);
      check("bq_empty", 32'(bq.size()), 32'd0);
      check("rq_empty", 32'(rq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
